// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a 2*WIDTH-bit accumulator.
// Define BOOTH_SIGNED_EN for two's-complement operands; leave it undefined for unsigned operands.
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_SIGNED_EN
   localparam bit SIGNED_MODE = 1'b1;
   localparam int DIGITS      = WIDTH / 2;
`else
   localparam bit SIGNED_MODE = 1'b0;
   localparam int DIGITS      = WIDTH / 2 + 1;
`endif

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   a_sh;
   logic [WIDTH+1:0] b_sh;
   logic            b_prev;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   sum;
   logic [PW-1:0]   a_ext;
   logic [2:0]      triplet;
   logic            load;
   logic            step;
   logic            last;

   assign ready   = (state != CALC);
   assign done    = (state == DONE);
   assign load    = ready && start;
   assign step    = (state == CALC) && !abort;
   assign last    = (cnt == CW'(DIGITS - 1));
   assign triplet = {b_sh[1:0], b_prev};
   assign a_ext   = SIGNED_MODE ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign sum     = acc + pp;

   // a_sh already carries the 2i weight, so the digit only selects +/- 1x or 2x.
   always_comb begin
      pp = '0;
      case (triplet)
         3'b001, 3'b010: pp = a_sh;
         3'b011:         pp = a_sh << 1;
         3'b100:         pp = -(a_sh << 1);
         3'b101, 3'b110: pp = -a_sh;
         default:        pp = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort is checked before the last-digit test so it wins on the same edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            if (abort)     state_next = IDLE;
            else if (last) state_next = DONE;
         end
         DONE: state_next = start ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         b_prev  <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         acc    <= '0;
         a_sh   <= a_ext;
         b_sh   <= {2'b00, b};
         b_prev <= 1'b0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= sum;
         a_sh   <= a_sh << 2;
         b_sh   <= b_sh >> 2;
         b_prev <= b_sh[1];
         cnt    <= cnt + 1'b1;
         if (last) product <= sum;
      end
   end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Iterative radix-4 Booth multiplier, parametrised in operand width. Recodes the multiplier into Booth digits in {-2,-1,0,+1,+2} and retires one digit per clock into a 2·WIDTH-bit accumulator, trading latency for area. Sits beside the fixed 8-bit combinational Booth encoder as its sequential, width-generic successor. It feeds the FMAC datapath through a start/ready/done handshake.

## Interface
- WIDTH, default 8: operand width. Must be even and ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only when ready=1.
- abort  in  1  cancels an operation in CALC.
- a  in  WIDTH  multiplicand. Latched on accepted start.
- b  in  WIDTH  multiplier. Latched on accepted start.
- ready  out  1  high when state ≠ CALC.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2·WIDTH  last completed result. Held until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - CALC: one Booth digit is processed per cycle.
  - DONE: lasts exactly one cycle.
- Digit count D:
  - D = WIDTH/2 in signed mode.
  - D = WIDTH/2+1 in unsigned mode, with b zero-extended by two bits.
- Digit i is formed from (b[2i+1], b[2i], b[2i-1]), with b[-1]=0. Encoding:
  - 000, 111 → 0
  - 001, 010 → +1
  - 011 → +2
  - 100 → -2
  - 101, 110 → -1
- Partial product: digit·A, extended to 2·WIDTH bits, then shifted left by 2i.
  - A is sign-extended in signed mode and zero-extended in unsigned mode.
  - The partial product is added to the accumulator modulo 2^(2·WIDTH).
- Transitions:
  - IDLE → CALC on start: latch a and b, clear the accumulator, set the digit counter to 0.
  - CALC → CALC while the counter < D-1.
  - On the D-th digit, CALC → DONE. The final sum is written into product and done=1 in the DONE cycle.
  - DONE → CALC if start=1 (back-to-back; new operands latched). Otherwise DONE → IDLE.
  - CALC → IDLE on abort=1, regardless of the counter. No done pulse; product is unchanged.
  - start while in CALC is ignored, and a/b changes are not observed.
- Abort has priority over completion on the same edge.
- The result equals the exact a·b (signed or unsigned per configuration), truncated to 2·WIDTH bits.

## Timing
- Reset, asynchronous on rst_n low:
  - state = IDLE, product = 0, done = 0, accumulator = 0, counter = 0.
  - ready = 1 throughout reset.
- Reset mid-CALC aborts immediately. No done pulse after release.
- Latency: start accepted at edge E0, so done=1 in the cycle after edge E0+D.
  - WIDTH=8 signed: done 4 cycles after the start edge.
  - WIDTH=8 unsigned: done 5 cycles after the start edge.
- Throughput: one result per D+1 cycles in back-to-back mode.
- done is high for exactly one cycle per completed operation.
- ready is a decode of state only, with no combinational path from inputs.

## Configuration
- BOOTH_SIGNED_EN defined: operands are two's complement. D = WIDTH/2, and a is sign-extended.
- BOOTH_SIGNED_EN undefined: operands are unsigned. D = WIDTH/2+1, the extra top digit is taken from (0, 0, b[WIDTH-1]), and a is zero-extended.
- The macro affects only digit count and extension; the handshake is identical in both builds.

## Test plan
- Unsigned build, WIDTH=8, a=255, b=255, start pulsed in IDLE → product=0xFE01, done high exactly 5 cycles after the start edge for one cycle, ready low for 5 cycles.
- Signed build, WIDTH=8, a=-128, b=-128 → product=0x4000. Next, a=-128, b=127 → 0xC080. a=0, b=-1 → 0x0000, done timing unchanged.
- Back-to-back: assert start in the DONE cycle with new operands (a=3, b=5) → second done exactly D+1 cycles after the first, product=15. Earlier product is held until then.
- abort asserted in the 2nd CALC cycle → IDLE next cycle, no done, product retains its previous value, ready=1.
- rst_n pulsed low mid-CALC → product=0, done=0, ready=1 immediately (asynchronous). A new start after release completes normally.
- Randomised sweep of a and b for WIDTH=8 and WIDTH=16, in both builds → product matches a reference multiply on every done. start during CALC is ignored.
